// File: rtl/wb_arbiter_pkg.sv
// Shared cpu types for the writeback arbiter slice: register address, data word
// and the queued write request.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [DATA_W-1:0]     uint32_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t addr;
        uint32_t   data;
    } wb_req_t;

    function automatic logic is_zero_reg(input reg_addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small queue of pending mul/div writebacks. Entries and valid bits are exported
// so the parent can build the pending-write mask and forwarding lookups.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_data,
    input  logic                  pop,
    output wb_req_t               head,
    output logic                  full,
    output logic                  empty,
    output wb_req_t [DEPTH-1:0]   entries,
    output logic    [DEPTH-1:0]   valid
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic    [PTR_W-1:0] wr_ptr;
    logic    [PTR_W-1:0] rd_ptr;
    wb_req_t [DEPTH-1:0] mem;
    logic    [DEPTH-1:0] valid_q;
    logic                push_ok;
    logic                pop_ok;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head    = mem[rd_ptr[IDX_W-1:0]];
    assign entries = mem;
    assign valid   = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
            mem     <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[IDX_W-1:0]]     <= push_data;
                valid_q[wr_ptr[IDX_W-1:0]] <= 1'b1;
                wr_ptr                     <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                valid_q[rd_ptr[IDX_W-1:0]] <= 1'b0;
                rd_ptr                     <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter merging the in-order pipeline with queued mul/div results onto
// one register file write port. Define WB_BYPASS_EN to forward pending write data.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_REG        = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 7,
    parameter int READ_PORTS   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pipe_we,
    input  reg_addr_t                        pipe_waddr,
    input  uint32_t                          pipe_wrdata,
    input  logic                             md_valid,
    input  reg_addr_t                        md_waddr,
    input  uint32_t                          md_wrdata,
    output logic                             md_ready,
    output logic                             stall_req,
    output logic                             we,
    output reg_addr_t                        waddr,
    output uint32_t                          wrdata,
    output logic      [N_REG-1:0]            pend_mask,
    input  reg_addr_t [READ_PORTS-1:0]       byp_raddr,
    output logic      [READ_PORTS-1:0]       byp_hit,
    output uint32_t   [READ_PORTS-1:0]       byp_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                  fifo_head;
    wb_req_t [FIFO_DEPTH-1:0] fifo_entries;
    logic    [FIFO_DEPTH-1:0] fifo_valid;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     pipe_valid;
    logic    [CNT_W-1:0]      starve_cnt;

    // Writes to register 0 complete the handshake but are never queued.
    assign md_ready   = !fifo_full;
    assign fifo_push  = md_valid && !fifo_full && !is_zero_reg(md_waddr);
    assign pipe_valid = pipe_we && !is_zero_reg(pipe_waddr);
    assign stall_req  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign fifo_pop   = !fifo_empty && (stall_req || !pipe_valid);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ('{addr: md_waddr, data: md_wrdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entries   (fifo_entries),
        .valid     (fifo_valid)
    );

    // The FIFO head wins whenever starvation forces a stall; the held pipeline
    // write is re-presented by the pipeline on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we         <= 1'b0;
            waddr      <= '0;
            wrdata     <= '0;
            starve_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                we     <= 1'b1;
                waddr  <= fifo_head.addr;
                wrdata <= fifo_head.data;
            end else if (pipe_valid) begin
                we     <= 1'b1;
                waddr  <= pipe_waddr;
                wrdata <= pipe_wrdata;
            end else begin
                we     <= 1'b0;
            end

            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
            if (fifo_valid[e]) begin
                pend_mask[fifo_entries[e].addr] = 1'b1;
            end
        end
        if (we) begin
            pend_mask[waddr] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // At most one write per register is ever pending, so matches can be OR-merged.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (!is_zero_reg(byp_raddr[p])) begin
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    if (fifo_valid[e] && (fifo_entries[e].addr == byp_raddr[p])) begin
                        byp_hit[p]  = 1'b1;
                        byp_data[p] = byp_data[p] | fifo_entries[e].data;
                    end
                end
                if (we && (waddr == byp_raddr[p])) begin
                    byp_hit[p]  = 1'b1;
                    byp_data[p] = byp_data[p] | wrdata;
                end
            end
        end
    end
`else
    logic unused_byp;

    assign byp_hit    = '0;
    assign byp_data   = '0;
    assign unused_byp = ^{byp_raddr, fifo_entries};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 7;
    localparam int RP    = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pipe_we;
    reg_addr_t          pipe_waddr;
    uint32_t            pipe_wrdata;
    logic               md_valid;
    reg_addr_t          md_waddr;
    uint32_t            md_wrdata;
    logic               md_ready;
    logic               stall_req;
    logic               we;
    reg_addr_t          waddr;
    uint32_t            wrdata;
    logic      [31:0]   pend_mask;
    reg_addr_t [RP-1:0] byp_raddr;
    logic      [RP-1:0] byp_hit;
    uint32_t   [RP-1:0] byp_data;

    wb_req_t   mq[$];
    logic      m_we;
    reg_addr_t m_addr;
    uint32_t   m_data;
    int        m_wait;
    logic      last_stall;
    logic      last_ready;
    int        checks = 0;
    int        passed = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .N_REG        (32),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .READ_PORTS   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wrdata (pipe_wrdata),
        .md_valid    (md_valid),
        .md_waddr    (md_waddr),
        .md_wrdata   (md_wrdata),
        .md_ready    (md_ready),
        .stall_req   (stall_req),
        .we          (we),
        .waddr       (waddr),
        .wrdata      (wrdata),
        .pend_mask   (pend_mask),
        .byp_raddr   (byp_raddr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        checks++;
        $display("[TB] FAIL %s: got timeout, wanted event", name);
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].addr] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic modelLookup(input reg_addr_t a, output logic hit, output uint32_t d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            foreach (mq[i]) if (mq[i].addr == a) begin hit = 1'b1; d = mq[i].data; end
            if (m_we && m_addr == a) begin hit = 1'b1; d = m_data; end
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_we       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_wait     = 0;
        last_stall = 1'b0;
        last_ready = 1'b1;
    endtask

    task automatic compareModel();
        logic    h;
        uint32_t d;
        checkOutput("we", 64'(we), 64'(m_we));
        checkOutput("waddr", 64'(waddr), 64'(m_addr));
        checkOutput("wrdata", 64'(wrdata), 64'(m_data));
        checkOutput("md_ready", 64'(md_ready), 64'(mq.size() < DEPTH));
        checkOutput("stall_req", 64'(stall_req), 64'(m_wait == LIMIT));
        checkOutput("pend_mask", 64'(pend_mask), 64'(modelMask()));
        for (int p = 0; p < RP; p++) begin
            modelLookup(byp_raddr[p], h, d);
`ifndef WB_BYPASS_EN
            h = 1'b0;
            d = '0;
`endif
            checkOutput($sformatf("byp_hit%0d", p), 64'(byp_hit[p]), 64'(h));
            checkOutput($sformatf("byp_data%0d", p), 64'(byp_data[p]), 64'(d));
        end
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic modelUpdate();
        logic    pv, stall, pop, was_empty, can_push;
        wb_req_t hd;
        pv        = pipe_we && (pipe_waddr != '0);
        stall     = (m_wait == LIMIT);
        was_empty = (mq.size() == 0);
        can_push  = (mq.size() < DEPTH);
        pop       = !was_empty && (stall || !pv);
        if (pop) begin
            hd     = mq.pop_front();
            m_we   = 1'b1;
            m_addr = hd.addr;
            m_data = hd.data;
        end else if (pv) begin
            m_we   = 1'b1;
            m_addr = pipe_waddr;
            m_data = pipe_wrdata;
        end else begin
            m_we   = 1'b0;
        end
        m_wait = (pop || was_empty) ? 0 : m_wait + 1;
        if (md_valid && can_push && md_waddr != '0) mq.push_back('{addr: md_waddr, data: md_wrdata});
        last_stall = stall;
        last_ready = can_push;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        compareModel();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_addr_t pickFree(input reg_addr_t excl);
        logic [31:0] busy = modelMask();
        reg_addr_t   a;
        for (int t = 0; t < 50; t++) begin
            a = reg_addr_t'($urandom_range(1, 31));
            if (!busy[a] && a != excl) return a;
        end
        return '0;
    endfunction

    // Random producers that respect the hold rules and the one-pending-write guarantee.
    task automatic applyStimulus();
        logic pipe_held;
        pipe_held = pipe_we && last_stall;
        if (!(md_valid && !last_ready)) begin
            md_valid  = ($urandom_range(0, 1) == 1);
            md_waddr  = ($urandom_range(0, 9) == 0) ? reg_addr_t'(0) : pickFree(pipe_held ? pipe_waddr : reg_addr_t'(0));
            md_wrdata = $urandom;
        end
        if (!pipe_held) begin
            pipe_we     = ($urandom_range(0, 2) != 0);
            pipe_waddr  = ($urandom_range(0, 9) == 0) ? reg_addr_t'(0) : pickFree(md_valid ? md_waddr : reg_addr_t'(0));
            pipe_wrdata = $urandom;
        end
        for (int p = 0; p < RP; p++) begin
            if ($urandom_range(0, 1) == 1 && mq.size() > 0)
                byp_raddr[p] = mq[$urandom_range(0, mq.size() - 1)].addr;
            else if ($urandom_range(0, 1) == 1 && m_we)
                byp_raddr[p] = m_addr;
            else
                byp_raddr[p] = reg_addr_t'($urandom_range(0, 31));
        end
    endtask

    task automatic drain();
        int n = 0;
        pipe_we  = 1'b0;
        md_valid = 1'b0;
        while ((mq.size() != 0 || m_we) && n < 40) begin
            stepCycle();
            n++;
        end
        if (n == 40) failNow("drain");
    endtask

    task automatic midReset();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_we", 64'(we), 64'd0);
        checkOutput("async_rst_pend", 64'(pend_mask), 64'd0);
        checkOutput("async_rst_ready", 64'(md_ready), 64'd1);
        checkOutput("async_rst_stall", 64'(stall_req), 64'd0);
        modelReset();
        pipe_we  = 1'b0;
        md_valid = 1'b0;
        @(negedge clk);
        compareModel();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int        k;
        logic      seen;
        uint32_t   held_data;

        modelReset();
        byp_raddr = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            pipe_we     = $urandom_range(0, 1) == 1;
            pipe_waddr  = reg_addr_t'($urandom_range(0, 31));
            pipe_wrdata = $urandom;
            md_valid    = $urandom_range(0, 1) == 1;
            md_waddr    = reg_addr_t'($urandom_range(0, 31));
            md_wrdata   = $urandom;
            @(negedge clk);
            checkOutput("rst_we", 64'(we), 64'd0);
            checkOutput("rst_ready", 64'(md_ready), 64'd1);
            checkOutput("rst_pend", 64'(pend_mask), 64'd0);
            checkOutput("rst_stall", 64'(stall_req), 64'd0);
            checkOutput("rst_waddr", 64'(waddr), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Pipeline write lands in the output register one edge later.
        pipe_we = 1'b1; pipe_waddr = 5; pipe_wrdata = 32'hDEADBEEF; md_valid = 1'b0;
        stepCycle();
        checkOutput("pipe_we", 64'(we), 64'd1);
        checkOutput("pipe_waddr", 64'(waddr), 64'd5);
        checkOutput("pipe_wrdata", 64'(wrdata), 64'hDEADBEEF);
        drain();

        // Idle pipeline: mul/div result appears two edges after the push.
        md_valid = 1'b1; md_waddr = 9; md_wrdata = 32'h12345678;
        stepCycle();
        md_valid = 1'b0;
        checkOutput("md_pend_rise", 64'(pend_mask[9]), 64'd1);
        checkOutput("md_we_early", 64'(we), 64'd0);
        stepCycle();
        checkOutput("md_we", 64'(we), 64'd1);
        checkOutput("md_waddr", 64'(waddr), 64'd9);
        checkOutput("md_wrdata", 64'(wrdata), 64'h12345678);
        stepCycle();
        checkOutput("md_pend_fall", 64'(pend_mask[9]), 64'd0);

        // Fill the queue behind a busy pipeline; the fifth result waits its turn.
        pipe_we = 1'b1; md_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_waddr = reg_addr_t'(20 + i); pipe_wrdata = $urandom;
            md_waddr = reg_addr_t'(10 + i); md_wrdata = 32'h1000 + 32'(i);
            stepCycle();
        end
        checkOutput("fill_not_ready", 64'(md_ready), 64'd0);
        md_waddr = 14; md_wrdata = 32'h1004;
        k = 4; seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (!last_stall) begin pipe_waddr = reg_addr_t'(20 + (k % 8)); pipe_wrdata = $urandom; k++; end
            stepCycle();
            seen = we && (waddr == 10);
        end
        if (!seen) failNow("fill_first_pop");
        checkOutput("fill_ready_after_pop", 64'(md_ready), 64'd1);
        checkOutput("fill_5th_waiting", 64'(pend_mask[14]), 64'd0);
        if (!last_stall) begin pipe_waddr = reg_addr_t'(20 + (k % 8)); pipe_wrdata = $urandom; end
        stepCycle();
        md_valid = 1'b0;
        checkOutput("fill_5th_queued", 64'(pend_mask[14]), 64'd1);
        drain();

        // Starvation: stall rises after the head has waited STARVE_LIMIT edges.
        pipe_we = 1'b1; pipe_waddr = 21; pipe_wrdata = $urandom;
        md_valid = 1'b1; md_waddr = 7; md_wrdata = 32'h77770007;
        stepCycle();
        md_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            pipe_waddr = reg_addr_t'(21 + i); pipe_wrdata = 32'hC0DE0000 + 32'(i);
            stepCycle();
            checkOutput($sformatf("starve_stall_%0d", i), 64'(stall_req), 64'(i == 7));
        end
        held_data = pipe_wrdata;
        stepCycle();
        checkOutput("starve_md_we", 64'(we), 64'd1);
        checkOutput("starve_md_addr", 64'(waddr), 64'd7);
        checkOutput("starve_md_data", 64'(wrdata), 64'h77770007);
        stepCycle();
        checkOutput("starve_pipe_addr", 64'(waddr), 64'd28);
        checkOutput("starve_pipe_data", 64'(wrdata), 64'(held_data));
        drain();

        // Zero register: pipe write to r0 lets the FIFO drain; md write to r0 is dropped.
        pipe_we = 1'b1; pipe_waddr = 22; pipe_wrdata = $urandom;
        md_valid = 1'b1; md_waddr = 11; md_wrdata = 32'hBEEF0011;
        stepCycle();
        md_valid = 1'b0; pipe_waddr = 0;
        stepCycle();
        checkOutput("zero_pipe_fifo_addr", 64'(waddr), 64'd11);
        pipe_we = 1'b0; md_valid = 1'b1; md_waddr = 0; md_wrdata = 32'h0BAD0BAD;
        stepCycle();
        md_valid = 1'b0;
        checkOutput("zero_md_pend", 64'(pend_mask), 64'd0);
        stepCycle();
        checkOutput("zero_md_no_write", 64'(we), 64'd0);

        // Forwarding lookup of a queued result.
        pipe_we = 1'b1; pipe_waddr = 24; pipe_wrdata = $urandom;
        md_valid = 1'b1; md_waddr = 3; md_wrdata = 32'hA5A5A5A5;
        byp_raddr[1] = 3; byp_raddr[0] = 0;
        stepCycle();
        md_valid = 1'b0;
        checkOutput("byp_hit0", 64'(byp_hit[0]), 64'd0);
`ifdef WB_BYPASS_EN
        checkOutput("byp_hit1", 64'(byp_hit[1]), 64'd1);
        checkOutput("byp_data1", 64'(byp_data[1]), 64'hA5A5A5A5);
`else
        checkOutput("byp_hit1", 64'(byp_hit[1]), 64'd0);
        checkOutput("byp_data1", 64'(byp_data[1]), 64'd0);
`endif
        drain();

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) midReset();
            applyStimulus();
            stepCycle();
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Single-port writeback arbiter in front of the GPR register file. It merges the in-order pipeline writeback stream with out-of-order results from the multi-cycle mul/div unit onto the register file's write port. Mul/div results are buffered in a small FIFO, and a registered write is driven to the register file. Exports a pending-write mask for the issue interlock, and optionally forwards queued data.

## Interface
- `N_REG`, 32, architectural register count (reg 0 hard-wired zero)
- `FIFO_DEPTH`, 4, mul/div result queue entries; power of two, ≥2
- `STARVE_LIMIT`, 7, max cycles a non-empty FIFO head may wait before stalling the pipeline; ≥1
- `READ_PORTS`, 2, forwarding lookup ports (used only with bypass compiled in)
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: asynchronous, active-low reset
- `pipe_we` in 1: pipeline writeback valid
- `pipe_waddr` in `reg_addr_t`: pipeline destination
- `pipe_wrdata` in `uint32_t`: pipeline result
- `md_valid` in 1: mul/div result valid
- `md_waddr` in `reg_addr_t`: mul/div destination
- `md_wrdata` in `uint32_t`: mul/div result
- `md_ready` out 1: FIFO can accept (= !full)
- `stall_req` out 1: pipeline must hold its writeback this cycle
- `we` out 1: register file write enable (registered)
- `waddr` out `reg_addr_t`: register file write address (registered)
- `wrdata` out `uint32_t`: register file write data (registered)
- `pend_mask` out `N_REG`: bit i set while a write to reg i is queued or in the output register
- `byp_raddr` in `READ_PORTS`×`reg_addr_t`: forwarding lookup address
- `byp_hit` out `READ_PORTS`: a pending write matches
- `byp_data` out `READ_PORTS`×`uint32_t`: matching pending data

## Operation
- Enqueue: on `md_valid && md_ready`, push {`md_waddr`, `md_wrdata`}. If `md_waddr`==0, the handshake completes and nothing is pushed.
- `md_ready` depends only on full. There is no same-cycle pop-to-push pass-through: a full FIFO refuses even when it pops that cycle.
- Issue select, evaluated each cycle, in priority order:
  - 1) If `stall_req`: pop the FIFO head into the output register. The pipeline write is not consumed; the pipeline re-presents it next cycle.
  - 2) Else if `pipe_we && pipe_waddr!=0`: load the pipeline write.
  - 3) Else if the FIFO is non-empty: pop the head.
  - 4) Else: `we`←0; `waddr`/`wrdata` hold their previous values.
- `pipe_we` with `pipe_waddr`==0 counts as no pipeline write, so the FIFO may drain that cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on pop or when the FIFO is empty.
  - `stall_req` = (count == `STARVE_LIMIT`), decoded from the register; it is high for exactly one cycle per starvation event.
- `pend_mask`: OR of one-hot(addr) over valid FIFO entries, plus the output register when `we`=1. Bit 0 is always 0.
- Upstream (issue interlock on `pend_mask`) guarantees at most one pending write per register. Therefore no WAW ordering logic is required.
- Pointer wrap: read/write pointers are log2(`FIFO_DEPTH`)+1 bits. Full = MSBs differ and the low bits are equal.

## Timing
- Reset values: `we`=0, `waddr`=0, `wrdata`=0, FIFO empty, counter=0, `stall_req`=0, `pend_mask`=0. `md_ready`=1 while reset is asserted and after it is released.
- Pipeline path: `pipe_we` sampled at edge k → `we`=1 during cycle k..k+1 → register file captures at edge k+1.
- Mul/div path: pushed at edge k, FIFO otherwise idle → popped at edge k+1 → `we`=1 during k+1..k+2. Minimum latency is 2 edges.
- `pend_mask` rises the cycle after the push edge. It falls the cycle after the output-register write drains.
- Reset asserted mid-operation clears all queued writes immediately, without waiting for a clock edge. Queued results are lost by design.

## Configuration
- `WB_BYPASS_EN` defined:
  - Each `byp_raddr[i]` is compared against all valid FIFO entries and the output register (when `we`=1).
  - `byp_hit[i]`=1 and `byp_data[i]` = matching data, combinational. Matches are OR-reduced because they are unique by guarantee.
  - raddr 0 never hits.
- `WB_BYPASS_EN` not defined:
  - `byp_hit`=0 and `byp_data`=0 constant; comparators are absent.
  - Consumers wait on `pend_mask` instead.

## Structure
- Shared cpu package: `uint32_t`, `reg_addr_t`, and a `wb_req_t` struct {`reg_addr_t` addr; `uint32_t` data}.
- One sub-module, `wb_fifo`:
  - Parameterised depth.
  - Push/pop/full/empty ports.
  - Exposes the entry array and valid bits, for `pend_mask` and bypass.
- Arbitration, starvation counter and output register live in `wb_arbiter`.

## Test plan
- Reset: hold `rst`=0 with random inputs → `we`=0, `md_ready`=1, `pend_mask`=0. Release, then `pipe_we`=1, addr 5, data 0xDEADBEEF → next cycle `we`=1, `waddr`=5, `wrdata`=0xDEADBEEF.
- Idle pipeline: md push addr 9, data 0x12345678 → `pend_mask[9]`=1 the next cycle → `we`=1 with addr 9 two cycles after the push → `pend_mask[9]`=0 the cycle after that.
- Fill: four md pushes while `pipe_we`=1 continuously → `md_ready`=0 after the 4th push. A 5th `md_valid` is held and not lost, and is accepted the cycle after the first pop.
- Starvation: one md push, then `pipe_we`=1 every cycle → `stall_req`=1 on the 7th waiting cycle. The FIFO entry is written and the held pipeline write issues the following cycle, with no write dropped.
- Zero register: `pipe_we` with addr 0 alongside a non-empty FIFO → the FIFO head issues. md push to addr 0 → no entry queued and `pend_mask`=0.
- Bypass (`WB_BYPASS_EN`): queue addr 3, data 0xA5A5A5A5; `byp_raddr[1]`=3 → `byp_hit[1]`=1 with data 0xA5A5A5A5. `byp_raddr[0]`=0 → `byp_hit[0]`=0. Without the macro → all hits 0.
